// File: rtl/riscv_mc_ctrl_if.sv
// Interface riscv_mc_ctrl_if.
// Carries the instruction word, the datapath status and the memory handshake
// into the multi-cycle RISC-V controller, and carries its control strobes back out.
// The controller connects as master. The datapath side, or a testbench, connects as slave.
interface riscv_mc_ctrl_if;
    logic [31:0] instr;
    logic        Zero;
    logic        mem_ack;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemToReg;
    logic        loadPC;
    logic [3:0]  ALUCtrl;
    logic        MemRead;
    logic        MemWrite;
    logic        mem_err;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instr, Zero, mem_ack,
        output PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, ALUCtrl,
               MemRead, MemWrite, mem_err, illegal, state
    );

    modport slave (
        output instr, Zero, mem_ack,
        input  PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, ALUCtrl,
               MemRead, MemWrite, mem_err, illegal, state
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Module riscv_mc_ctrl: multi-cycle RISC-V control FSM (IF, ID, EX, MEM, WB, HALT).
// The data-memory wait is bounded by MEM_TIMEOUT cycles.
// Optional macro RISCV_MC_CTRL_ILLEGAL_HALT_EN:
//   - when defined, an unknown opcode halts the FSM and sets the sticky illegal flag;
//   - when undefined, an unknown opcode executes as a NOP.
module riscv_mc_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    riscv_mc_ctrl_if.master bus
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       mem_err_reg, mem_err_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       is_load, is_store, is_itype, is_rtype, is_branch;
    logic [3:0] alu_rr;

    logic       pc_src, alu_src, reg_write, mem_to_reg, load_pc, mem_read, mem_write;
    logic [3:0] alu_ctrl;
    logic       unused_bits;

    assign opcode    = bus.instr[6:0];
    assign funct3    = bus.instr[14:12];
    assign funct7_b5 = bus.instr[30];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_itype  = (opcode == OP_ITYPE);
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_branch = (opcode == OP_BRANCH);

    // Register operand fields and immediates belong to the datapath.
    assign unused_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // ALU operation for R/I arithmetic.
    // Bit 30 selects SUB only for register-register operations.
    // Bit 30 selects arithmetic right shift for both R and I shift-right forms.
    // SLTU has no dedicated code, so it shares the SLT encoding.
    always_comb begin
        case (funct3)
            3'b000:  alu_rr = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_rr = ALU_SLL;
            3'b010:  alu_rr = ALU_SLT;
            3'b011:  alu_rr = ALU_SLT;
            3'b100:  alu_rr = ALU_XOR;
            3'b101:  alu_rr = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_rr = ALU_OR;
            default: alu_rr = ALU_AND;
        endcase
    end

`ifdef RISCV_MC_CTRL_ILLEGAL_HALT_EN
    logic illegal_reg;
    logic illegal_set;
`endif

    // Next-state logic and Moore/Mealy control strobes decoded from the state and the instruction.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = 1'b0;
        pc_src        = 1'b0;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        load_pc       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_ctrl      = ALU_ADD;
`ifdef RISCV_MC_CTRL_ILLEGAL_HALT_EN
        illegal_set   = 1'b0;
`endif
        case (state_reg)
            S_IF: state_next = S_ID;
            S_ID: state_next = S_EX;
            S_EX: begin
                wait_cnt_next = 8'd0;
                alu_src       = is_itype | is_load | is_store;
                if (is_load || is_store) begin
                    state_next = S_MEM;
                end else if (is_itype || is_rtype) begin
                    alu_ctrl   = alu_rr;
                    state_next = S_WB;
                end else if (is_branch) begin
                    alu_ctrl   = ALU_SUB;
                    load_pc    = 1'b1;
                    pc_src     = (funct3 == 3'b000) ? bus.Zero :
                                 (funct3 == 3'b001) ? ~bus.Zero : 1'b0;
                    state_next = S_IF;
                end else begin
`ifdef RISCV_MC_CTRL_ILLEGAL_HALT_EN
                    illegal_set = 1'b1;
                    state_next  = S_HALT;
`else
                    load_pc    = 1'b1;
                    state_next = S_IF;
`endif
                end
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
                if (bus.mem_ack) begin
                    if (is_load) begin
                        state_next = S_WB;
                    end else begin
                        load_pc    = 1'b1;
                        state_next = S_IF;
                    end
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // An acknowledge arriving in the final wait cycle still completes normally.
                    load_pc      = 1'b1;
                    mem_err_next = 1'b1;
                    state_next   = S_IF;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                load_pc    = 1'b1;
                mem_to_reg = is_load;
                alu_src    = is_itype | is_load;
                alu_ctrl   = is_load ? ALU_ADD : alu_rr;
                state_next = S_IF;
            end
            S_HALT: begin
`ifdef RISCV_MC_CTRL_ILLEGAL_HALT_EN
                state_next = S_HALT;
`else
                state_next = S_IF;
`endif
            end
            default: state_next = S_IF;
        endcase
    end

    // State, wait counter and timeout pulse registers. Reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= S_IF;
            wait_cnt_reg <= 8'd0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

`ifdef RISCV_MC_CTRL_ILLEGAL_HALT_EN
    // Sticky illegal-opcode flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            illegal_reg <= 1'b0;
        end else if (illegal_set) begin
            illegal_reg <= 1'b1;
        end
    end
    assign bus.illegal = illegal_reg;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.PCSrc    = pc_src;
    assign bus.ALUSrc   = alu_src;
    assign bus.RegWrite = reg_write;
    assign bus.MemToReg = mem_to_reg;
    assign bus.loadPC   = load_pc;
    assign bus.ALUCtrl  = alu_ctrl;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.mem_err  = mem_err_reg;
    assign bus.state    = state_reg;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Testbench tb_riscv_mc_ctrl for riscv_mc_ctrl.
// The bench applies a table of directed instructions, then two hand-written
// corner cases (reset during a MEM wait, and halt recovery), then random instructions.
// Each instruction's observed per-cycle trace is compared with a model computed from
// the instruction class.
// The same file serves both builds, with or without RISCV_MC_CTRL_ILLEGAL_HALT_EN.
module tb_riscv_mc_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    riscv_mc_ctrl_if bus ();

    riscv_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] seq;
        int len, regwrite, memread, memwrite, memtoreg, loadpc, pcsrc_lp;
        int memerr, alu_bad, alusrc_bad, idle_bad, illegal, halt;
        logic [3:0] alu;
        logic alusrc;
    } trace_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          ack_at;
        int          exp_len;
        logic [3:0]  exp_alu;
        int          exp_pcsrc;
        int          exp_err;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected behaviour of one instruction, built from its class rather than from state logic.
    function automatic trace_t model(input logic [31:0] ins, input logic z, input int ack_at);
        trace_t t;
        int     st_q[$];
        logic [6:0] op;
        logic [2:0] f3;
        logic b30;
        bit ld, sd, ri, rr, br, ackok;
        int m;
        t = '{default: 0};
        op = ins[6:0]; f3 = ins[14:12]; b30 = ins[30];
        ld = (op == 7'b0000011); sd = (op == 7'b0100011);
        ri = (op == 7'b0010011); rr = (op == 7'b0110011); br = (op == 7'b1100011);
        ackok = (ack_at >= 1) && (ack_at <= TO);
        m = ackok ? ack_at : TO;
        st_q = '{0, 1, 2};
        t.alu = 4'b0010;
        if (br) t.alu = 4'b0110;
        if (ri || rr) begin
            case (f3)
                3'd0: t.alu = (rr && b30) ? 4'b0110 : 4'b0010;
                3'd1: t.alu = 4'b0100;
                3'd2, 3'd3: t.alu = 4'b1000;
                3'd4: t.alu = 4'b0011;
                3'd5: t.alu = b30 ? 4'b0111 : 4'b0101;
                3'd6: t.alu = 4'b0001;
                default: t.alu = 4'b0000;
            endcase
        end
        t.alusrc = ri | ld | sd;
        t.loadpc = 1;
        if (ri || rr) begin
            st_q.push_back(4);
            t.regwrite = 1;
        end else if (ld || sd) begin
            for (int k = 0; k < m; k++) st_q.push_back(3);
            if (ld) t.memread = m; else t.memwrite = m;
            if (!ackok) t.memerr = 1;
            if (ld && ackok) begin
                st_q.push_back(4);
                t.regwrite = 1;
                t.memtoreg = 1;
            end
        end else if (br) begin
            t.pcsrc_lp = ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z)) ? 1 : 0;
        end else begin
`ifdef RISCV_MC_CTRL_ILLEGAL_HALT_EN
            st_q.push_back(5);
            t.halt = 1;
            t.illegal = 1;
            t.loadpc = 0;
`endif
        end
        foreach (st_q[k]) begin
            t.seq = (t.seq << 4) | 64'(st_q[k]);
            t.len++;
        end
        return t;
    endfunction

    // Run one instruction starting at a falling edge in IF. The task stops on the
    // first return to IF, or on reaching HALT.
    task automatic run(input logic [31:0] ins, input logic z, input int ack_at,
                       input trace_t e, output trace_t o);
        int memcyc;
        int cyc;
        bit done;
        o = '{default: 0};
        memcyc = 0; cyc = 0; done = 0;
        bus.instr = ins;
        bus.Zero  = z;
        while (!done) begin
            bus.mem_ack = 1'b0;
            if (bus.state == 3'd3) begin
                memcyc++;
                bus.mem_ack = (memcyc == ack_at);
            end
            #1;
            o.seq = (o.seq << 4) | 64'(bus.state);
            o.len++;
            o.regwrite += int'(bus.RegWrite);
            o.memread  += int'(bus.MemRead);
            o.memwrite += int'(bus.MemWrite);
            o.memtoreg += int'(bus.MemToReg);
            o.loadpc   += int'(bus.loadPC);
            o.pcsrc_lp += int'(bus.loadPC && bus.PCSrc);
            if (bus.state == 3'd2) begin
                o.alu    = bus.ALUCtrl;
                o.alusrc = bus.ALUSrc;
            end
            if (bus.state == 3'd3 || bus.state == 3'd4) begin
                o.alu_bad    += int'(bus.ALUCtrl !== e.alu);
                o.alusrc_bad += int'(bus.ALUSrc !== e.alusrc);
            end
            if (bus.state == 3'd0 || bus.state == 3'd1 || bus.state == 3'd5) begin
                o.idle_bad += int'(({bus.PCSrc, bus.ALUSrc, bus.RegWrite, bus.MemToReg,
                                     bus.loadPC, bus.MemRead, bus.MemWrite} != 7'd0) ||
                                    (bus.ALUCtrl !== 4'b0010));
            end
            if (cyc > 0) o.memerr += int'(bus.mem_err);
            o.illegal = int'(bus.illegal);
            cyc++;
            if (bus.state == 3'd5) begin
                done = 1;
            end else begin
                @(negedge clk);
                if (bus.state == 3'd0) begin
                    #1;
                    o.memerr += int'(bus.mem_err);
                    o.illegal = int'(bus.illegal);
                    done = 1;
                end else if (cyc >= 40) begin
                    check("run_budget", 64'(cyc), 64'd0);
                    done = 1;
                end
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic compare(input string n, input trace_t o, input trace_t e);
        check({n, "_seq"}, o.seq, e.seq);
        check({n, "_len"}, 64'(o.len), 64'(e.len));
        check({n, "_regwrite"}, 64'(o.regwrite), 64'(e.regwrite));
        check({n, "_memread"}, 64'(o.memread), 64'(e.memread));
        check({n, "_memwrite"}, 64'(o.memwrite), 64'(e.memwrite));
        check({n, "_memtoreg"}, 64'(o.memtoreg), 64'(e.memtoreg));
        check({n, "_loadpc"}, 64'(o.loadpc), 64'(e.loadpc));
        check({n, "_pcsrc"}, 64'(o.pcsrc_lp), 64'(e.pcsrc_lp));
        check({n, "_alu_ex"}, 64'(o.alu), 64'(e.alu));
        check({n, "_alusrc_ex"}, 64'(o.alusrc), 64'(e.alusrc));
        check({n, "_alu_memwb"}, 64'(o.alu_bad), 64'd0);
        check({n, "_alusrc_memwb"}, 64'(o.alusrc_bad), 64'd0);
        check({n, "_idle_strobes"}, 64'(o.idle_bad), 64'd0);
        check({n, "_mem_err"}, 64'(o.memerr), 64'(e.memerr));
        check({n, "_illegal"}, 64'(o.illegal), 64'(e.illegal));
    endtask

    // HALT must hold with strobes low until reset; reset clears the sticky flag.
    task automatic halt_recover(input string n);
        repeat (3) begin
            @(negedge clk);
            #1;
            check({n, "_halt_state"}, 64'(bus.state), 64'd5);
            check({n, "_halt_illegal"}, 64'(bus.illegal), 64'd1);
            check({n, "_halt_strobes"}, 64'({bus.PCSrc, bus.ALUSrc, bus.RegWrite, bus.MemToReg,
                                             bus.loadPC, bus.MemRead, bus.MemWrite, bus.mem_err}), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check({n, "_halt_rst_illegal"}, 64'(bus.illegal), 64'd0);
        check({n, "_halt_rst_state"}, 64'(bus.state), 64'd0);
        rst = 1'b1;
    endtask

    task automatic do_instr(input string n, input logic [31:0] ins, input logic z,
                            input int ack_at, output trace_t o);
        trace_t e;
        e = model(ins, z, ack_at);
        run(ins, z, ack_at, e, o);
        compare(n, o, e);
        $display("[TB] %s instr=%08h zero=%0b ack_at=%0d states=%0h", n, ins, z, ack_at, o.seq);
        if (e.halt != 0) halt_recover(n);
    endtask

    vec_t   vecs[15];
    trace_t o;
    int     guard;

    initial begin
        // Table columns: instr, Zero, ack cycle (0 means no ack), cycle count, EX ALUCtrl,
        // taken branch, mem_err.
        vecs[0]  = '{32'h002081B3, 1'b0, 0, 4, 4'b0010, 0, 0};  // add
        vecs[1]  = '{32'h402081B3, 1'b0, 0, 4, 4'b0110, 0, 0};  // sub
        vecs[2]  = '{32'h00208063, 1'b1, 0, 3, 4'b0110, 1, 0};  // beq taken
        vecs[3]  = '{32'h00208063, 1'b0, 0, 3, 4'b0110, 0, 0};  // beq not taken
        vecs[4]  = '{32'h00209063, 1'b0, 0, 3, 4'b0110, 1, 0};  // bne taken
        vecs[5]  = '{32'h0020C063, 1'b1, 0, 3, 4'b0110, 0, 0};  // blt acts not-taken
        vecs[6]  = '{32'h0000A183, 1'b0, 3, 7, 4'b0010, 0, 0};  // lw, ack on 3rd MEM cycle
        vecs[7]  = '{32'h0030A023, 1'b0, 0, 7, 4'b0010, 0, 1};  // sw timeout
        vecs[8]  = '{32'h0030A023, 1'b0, 1, 4, 4'b0010, 0, 0};  // sw, immediate ack
        vecs[9]  = '{32'h0000A183, 1'b0, 0, 7, 4'b0010, 0, 1};  // lw timeout
        vecs[10] = '{32'h0000A183, 1'b0, 4, 8, 4'b0010, 0, 0};  // lw, ack on expiry cycle
        vecs[11] = '{32'h4030D093, 1'b0, 0, 4, 4'b0111, 0, 0};  // srai
        vecs[12] = '{32'h40008093, 1'b0, 0, 4, 4'b0010, 0, 0};  // addi, bit30 set
        vecs[13] = '{32'h0020A1B3, 1'b0, 0, 4, 4'b1000, 0, 0};  // slt
`ifdef RISCV_MC_CTRL_ILLEGAL_HALT_EN
        vecs[14] = '{32'h0000007F, 1'b0, 0, 4, 4'b0010, 0, 0};  // illegal -> HALT
`else
        vecs[14] = '{32'h0000007F, 1'b0, 0, 3, 4'b0010, 0, 0};  // illegal -> NOP
`endif

        bus.instr   = 32'h0;
        bus.Zero    = 1'b0;
        bus.mem_ack = 1'b0;
        rst         = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_strobes", 64'({bus.PCSrc, bus.ALUSrc, bus.RegWrite, bus.MemToReg, bus.loadPC,
                                  bus.MemRead, bus.MemWrite, bus.mem_err, bus.illegal}), 64'd0);
        check("rst_aluctrl", 64'(bus.ALUCtrl), 64'b0010);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            string n;
            n = $sformatf("vec%0d", i);
            do_instr(n, vecs[i].instr, vecs[i].zero, vecs[i].ack_at, o);
            check({n, "_tbl_len"}, 64'(o.len), 64'(vecs[i].exp_len));
            check({n, "_tbl_alu"}, 64'(o.alu), 64'(vecs[i].exp_alu));
            check({n, "_tbl_pcsrc"}, 64'(o.pcsrc_lp), 64'(vecs[i].exp_pcsrc));
            check({n, "_tbl_err"}, 64'(o.memerr), 64'(vecs[i].exp_err));
        end

        // Reset during the second MEM cycle of a store that is never acknowledged.
        bus.instr   = 32'h0030A023;
        bus.mem_ack = 1'b0;
        guard = 0;
        while (bus.state != 3'd3 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("rstmem_reach_mem", 64'(bus.state), 64'd3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmem_state", 64'(bus.state), 64'd0);
        check("rstmem_memwrite", 64'(bus.MemWrite), 64'd0);
        check("rstmem_mem_err", 64'(bus.mem_err), 64'd0);
        check("rstmem_regwrite_loadpc", 64'({bus.RegWrite, bus.loadPC}), 64'd0);
        @(negedge clk);
        check("rstmem_mem_err_hold", 64'(bus.mem_err), 64'd0);
        rst = 1'b1;
        $display("[TB] rstmem store reset mid-wait state=%0d", bus.state);

        // Random instructions. The instruction class is chosen first; the other fields are free.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            logic [6:0]  opc;
            int cls;
            r   = $urandom;
            cls = int'($urandom_range(0, 5));
            case (cls)
                0: opc = 7'b0110011;
                1: opc = 7'b0010011;
                2: opc = 7'b0000011;
                3: opc = 7'b0100011;
                4: opc = 7'b1100011;
                default: opc = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h37;
            endcase
            do_instr($sformatf("rnd%0d", i), {r[31:7], opc}, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, TO + 1)), o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
